// File: rtl/sift_seq_pkg.sv
// Shared types and constants for the SIFT phase sequencer.
package sift_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_RUN    = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_e;

    localparam int PH_GAUSSIAN = 0;
    localparam int PH_DETECT   = 1;
    localparam int PH_MATCH    = 2;

    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_NUM_BANKS = 4;

endpackage

// File: rtl/sift_seq_mux.sv
// Routes the selected phase's image/blur addresses and line-buffer write enable
// onto the shared memory ports; everything is forced to zero when en_i is low.
module sift_seq_mux #(
    parameter int NUM_PHASES = 3,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_W     = 9,
    parameter int PH_W       = 2
) (
    input  logic                              en_i,
    input  logic [PH_W-1:0]                   sel_i,
    input  logic [NUM_PHASES*ADDR_W-1:0]      phase_img_addr_i,
    input  logic [NUM_PHASES*NUM_BANKS*ADDR_W-1:0] phase_blur_addr_i,
    input  logic [NUM_PHASES-1:0]             phase_buffer_we_i,
    output logic [ADDR_W-1:0]                 img_addr_o,
    output logic [NUM_BANKS*ADDR_W-1:0]       blur_addr_o,
    output logic                              buffer_we_o
);

    localparam int BLUR_W = NUM_BANKS * ADDR_W;

    always_comb begin
        img_addr_o  = '0;
        blur_addr_o = '0;
        buffer_we_o = 1'b0;
        if (en_i) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (sel_i == PH_W'(i)) begin
                    img_addr_o  = phase_img_addr_i[i*ADDR_W +: ADDR_W];
                    blur_addr_o = phase_blur_addr_i[i*BLUR_W +: BLUR_W];
                    buffer_we_o = phase_buffer_we_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/sift_phase_sequencer.sv
// Top-level SIFT phase controller: runs the enabled engines in index order with a
// start/done handshake, per-phase watchdog, abort and cycle profiling.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | waiting for start
//   ST_SELECT | find lowest enabled phase >= nxt; one-cycle gap between phases
//   ST_RUN    | phase_start of cur_phase high, counting cycles until its done
//   ST_FINISH | one-cycle done pulse
//   ST_ERROR  | watchdog expired; held until abort or reset
module sift_phase_sequencer
    import sift_seq_pkg::*;
#(
    parameter int NUM_PHASES     = 3,
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int CNT_W          = 20,
    parameter int TIMEOUT_CYCLES = 2**20 - 1,
    parameter int PH_W           = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic [NUM_PHASES-1:0]                  phase_en_i,
    input  logic [NUM_PHASES-1:0]                  phase_done_i,
    input  logic [NUM_PHASES*ADDR_W-1:0]           phase_img_addr_i,
    input  logic [NUM_PHASES*NUM_BANKS*ADDR_W-1:0] phase_blur_addr_i,
    input  logic [NUM_PHASES-1:0]                  phase_buffer_we_i,
    output logic [NUM_PHASES-1:0]                  phase_start_o,
    output logic [ADDR_W-1:0]                      img_addr_o,
    output logic [NUM_BANKS*ADDR_W-1:0]            blur_addr_o,
    output logic                                   buffer_we_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   error_o,
    output logic [PH_W-1:0]                        err_phase_o,
    output logic [PH_W-1:0]                        cur_phase_o,
    output logic [CNT_W-1:0]                       last_cycles_o
);

    // nxt must be able to point one past the last phase
    localparam int NXT_W = $clog2(NUM_PHASES + 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W:0] TIMEOUT_L = (CNT_W+1)'(TIMEOUT_CYCLES);

    seq_state_e              state_q, state_d;
    logic [NUM_PHASES-1:0]   en_q, en_d;
    logic [NXT_W-1:0]        nxt_q, nxt_d;
    logic [PH_W-1:0]         cur_phase_q, cur_phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        last_cycles_q, last_cycles_d;
    logic [PH_W-1:0]         err_phase_q, err_phase_d;

    logic                    found;
    logic [PH_W-1:0]         sel_idx;
    logic [CNT_W:0]          cnt_inc;
    logic [CNT_W-1:0]        cnt_sat;
    logic                    run_active;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (en_q[i] && (NXT_W'(i) >= nxt_q)) begin
                found   = 1'b1;
                sel_idx = PH_W'(i);
            end
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign cnt_sat = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];

    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        nxt_d         = nxt_q;
        cur_phase_d   = cur_phase_q;
        cnt_d         = cnt_q;
        last_cycles_d = last_cycles_q;
        err_phase_d   = err_phase_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    en_d    = phase_en_i;
                    nxt_d   = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (found) begin
                    cur_phase_d = sel_idx;
                    cnt_d       = '0;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_sat;
                // completion takes precedence over a coincident watchdog expiry
                if (phase_done_i[cur_phase_q]) begin
                    last_cycles_d = cnt_sat;
                    nxt_d         = NXT_W'(cur_phase_q) + NXT_W'(1);
                    state_d       = ST_SELECT;
                end else if (WDOG_EN && (cnt_inc == TIMEOUT_L)) begin
                    err_phase_d = cur_phase_q;
                    state_d     = ST_ERROR;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            en_q          <= '0;
            nxt_q         <= '0;
            cur_phase_q   <= '0;
            cnt_q         <= '0;
            last_cycles_q <= '0;
            err_phase_q   <= '0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            nxt_q         <= nxt_d;
            cur_phase_q   <= cur_phase_d;
            cnt_q         <= cnt_d;
            last_cycles_q <= last_cycles_d;
            err_phase_q   <= err_phase_d;
        end
    end

    assign run_active = (state_q == ST_RUN);

    always_comb begin
        phase_start_o = '0;
        if (run_active) begin
            phase_start_o[cur_phase_q] = 1'b1;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_FINISH);
    assign error_o       = (state_q == ST_ERROR);
    assign err_phase_o   = err_phase_q;
    assign cur_phase_o   = cur_phase_q;
    assign last_cycles_o = last_cycles_q;

    sift_seq_mux #(
        .NUM_PHASES (NUM_PHASES),
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_W     (ADDR_W),
        .PH_W       (PH_W)
    ) u_mux (
        .en_i              (run_active),
        .sel_i             (cur_phase_q),
        .phase_img_addr_i  (phase_img_addr_i),
        .phase_blur_addr_i (phase_blur_addr_i),
        .phase_buffer_we_i (phase_buffer_we_i),
        .img_addr_o        (img_addr_o),
        .blur_addr_o       (blur_addr_o),
        .buffer_we_o       (buffer_we_o)
    );

endmodule

// File: tb/tb_sift_phase_sequencer.sv
// Directed bench for sift_phase_sequencer: two instances share stimulus, one with
// a 16-cycle watchdog and one with an 8-cycle watchdog for the boundary case.
module tb_sift_phase_sequencer;
    import sift_seq_pkg::*;

    localparam int NP = 3;
    localparam int NB = 4;
    localparam int AW = 9;
    localparam int CW = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort;
    logic [NP-1:0]       phase_en, phase_done, phase_buffer_we;
    logic [NP*AW-1:0]    phase_img_addr;
    logic [NP*NB*AW-1:0] phase_blur_addr;

    logic [NP-1:0]    phase_start, phase_start_b;
    logic [AW-1:0]    img_addr, img_addr_b;
    logic [NB*AW-1:0] blur_addr, blur_addr_b;
    logic             buffer_we, buffer_we_b;
    logic             busy, busy_b, done, done_b, error, error_b;
    logic [1:0]       err_phase, err_phase_b, cur_phase, cur_phase_b;
    logic [CW-1:0]    last_cycles, last_cycles_b;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sift_phase_sequencer #(.NUM_PHASES(NP), .NUM_BANKS(NB), .ADDR_W(AW), .CNT_W(CW),
                           .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .phase_en_i(phase_en), .phase_done_i(phase_done),
        .phase_img_addr_i(phase_img_addr), .phase_blur_addr_i(phase_blur_addr),
        .phase_buffer_we_i(phase_buffer_we),
        .phase_start_o(phase_start), .img_addr_o(img_addr), .blur_addr_o(blur_addr),
        .buffer_we_o(buffer_we), .busy_o(busy), .done_o(done), .error_o(error),
        .err_phase_o(err_phase), .cur_phase_o(cur_phase), .last_cycles_o(last_cycles)
    );

    sift_phase_sequencer #(.NUM_PHASES(NP), .NUM_BANKS(NB), .ADDR_W(AW), .CNT_W(CW),
                           .TIMEOUT_CYCLES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .phase_en_i(phase_en), .phase_done_i(phase_done),
        .phase_img_addr_i(phase_img_addr), .phase_blur_addr_i(phase_blur_addr),
        .phase_buffer_we_i(phase_buffer_we),
        .phase_start_o(phase_start_b), .img_addr_o(img_addr_b), .blur_addr_o(blur_addr_b),
        .buffer_we_o(buffer_we_b), .busy_o(busy_b), .done_o(done_b), .error_o(error_b),
        .err_phase_o(err_phase_b), .cur_phase_o(cur_phase_b), .last_cycles_o(last_cycles_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start asserted in cycle 0; returns in the cycle-1 window with start low
    task automatic launch(input logic [NP-1:0] en);
        phase_en = en;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    logic [NP-1:0]    exp_ps;
    logic [AW-1:0]    exp_img;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        phase_en = '0; phase_done = '0; phase_buffer_we = '0;
        phase_img_addr = '0; phase_blur_addr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_phase_start", phase_start, 0);
        check_val("rst_last_cycles", last_cycles, 0);
        check_val("rst_error", error, 0);
        check_val("rst_done", done, 0);
        tick();

        // all three phases, done in RUN cycles 5/7/3
        launch(3'b111);
        for (int c = 1; c <= 21; c++) begin
            phase_done = (c == 6) ? 3'b001 : (c == 14) ? 3'b010 : (c == 18) ? 3'b100 : 3'b000;
            #1;
            exp_ps = (c >= 2 && c <= 6) ? 3'b001 : (c >= 8 && c <= 14) ? 3'b010 :
                     (c >= 16 && c <= 18) ? 3'b100 : 3'b000;
            check_val($sformatf("t1_phase_start@%0d", c), phase_start, exp_ps);
            check_val($sformatf("t1_done@%0d", c), done, (c == 20) ? 1 : 0);
            if (c == 7)  check_val("t1_last_cycles_p0", last_cycles, 5);
            if (c == 10) check_val("t1_cur_phase", cur_phase, PH_DETECT);
            if (c == 15) check_val("t1_last_cycles_p1", last_cycles, 7);
            if (c == 20) check_val("t1_last_cycles_p2", last_cycles, 3);
            if (c == 20) check_val("t1_error_b", error_b, 0);
            if (c == 21) check_val("t1_busy_end", busy, 0);
            tick();
        end
        phase_done = '0;

        // phases 0 and 2 only; mux routing, non-active done ignored
        phase_img_addr = {9'h033, 9'h022, 9'h011};
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < NB; b++)
                phase_blur_addr[(p*NB+b)*AW +: AW] = AW'(p*16 + b + 1);
        phase_buffer_we = 3'b100;
        launch(3'b101);
        for (int c = 1; c <= 9; c++) begin
            phase_done = (c == 2) ? 3'b010 : (c == 3) ? 3'b001 : (c == 6) ? 3'b100 : 3'b000;
            #1;
            exp_img = (c == 2 || c == 3) ? 9'h011 : (c == 5 || c == 6) ? 9'h033 : 9'h000;
            check_val($sformatf("t2_img_addr@%0d", c), img_addr, exp_img);
            check_val($sformatf("t2_ps1@%0d", c), phase_start[1], 0);
            check_val($sformatf("t2_buffer_we@%0d", c), buffer_we, (c == 5 || c == 6) ? 1 : 0);
            if (c == 2) check_val("t2_blur_p0", blur_addr, {9'h004, 9'h003, 9'h002, 9'h001});
            if (c == 5) check_val("t2_blur_p2", blur_addr, {9'h024, 9'h023, 9'h022, 9'h021});
            if (c == 4) check_val("t2_blur_select", blur_addr, 0);
            if (c == 8) check_val("t2_done", done, 1);
            if (c == 9) check_val("t2_busy_end", busy, 0);
            tick();
        end
        phase_done = '0;
        phase_buffer_we = '0;

        // phase 1 never completes; watchdog of 16
        launch(3'b010);
        for (int c = 1; c <= 18; c++) begin
            phase_done = 3'b001;
            #1;
            check_val($sformatf("t3_error@%0d", c), error, (c == 18) ? 1 : 0);
            if (c == 17) check_val("t3_ps_last_run", phase_start, 3'b010);
            if (c == 18) begin
                check_val("t3_err_phase", err_phase, 1);
                check_val("t3_phase_start", phase_start, 0);
                check_val("t3_busy", busy, 1);
                check_val("t3_done", done, 0);
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check_val("t3_start_ignored", error, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check_val("t3_abort_error", error, 0);
        check_val("t3_abort_busy", busy, 0);
        check_val("t3_abort_error_b", error_b, 0);
        phase_done = '0;
        tick();

        // empty mask, second start in cycle 1
        launch(3'b000);
        start = 1'b1;
        #1;
        check_val("t4_busy_c1", busy, 1);
        tick();
        start = 1'b0;
        #1;
        check_val("t4_done_c2", done, 1);
        tick();
        check_val("t4_busy_c3", busy, 0);
        check_val("t4_done_c3", done, 0);
        tick();
        check_val("t4_busy_c4", busy, 0);
        check_val("t4_done_c4", done, 0);

        // abort in 3rd RUN cycle of phase 0
        launch(3'b111);
        tick();
        tick();
        #1;
        check_val("t5_ps_c3", phase_start, 3'b001);
        tick();
        abort = 1'b1;
        #1;
        tick();
        abort = 1'b0;
        #1;
        check_val("t5_busy_after_abort", busy, 0);
        check_val("t5_ps_after_abort", phase_start, 0);
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("t5_no_done@%0d", c), done, 0);
            tick();
        end
        launch(3'b001);
        check_val("t5_fresh_select", phase_start, 0);
        tick();
        phase_done = 3'b001;
        #1;
        check_val("t5_fresh_run", phase_start, 3'b001);
        tick();
        phase_done = 3'b000;
        #1;
        check_val("t5_fresh_last", last_cycles, 1);
        tick();
        check_val("t5_fresh_done", done, 1);
        tick();

        // watchdog of 8 with done exactly on RUN cycle 8
        launch(3'b011);
        for (int c = 1; c <= 13; c++) begin
            phase_done = (c == 9) ? 3'b001 : (c == 11) ? 3'b010 : 3'b000;
            #1;
            if (c == 9)  check_val("t6_ps_c9", phase_start_b, 3'b001);
            if (c == 10) begin
                check_val("t6_error_b", error_b, 0);
                check_val("t6_last_b", last_cycles_b, 8);
                check_val("t6_busy_b", busy_b, 1);
            end
            if (c == 11) check_val("t6_ps_next", phase_start_b, 3'b010);
            if (c == 13) check_val("t6_done_b", done_b, 1);
            tick();
        end
        phase_done = '0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
